uart_imem_loader: RTL and testbench

Parametrised successor to the core's UART instruction-memory programming path. It receives a framed byte stream on a UART line while `prog` is high and assembles the bytes into DATA_W-bit words. Each word is written into instruction memory through a single-cycle write strobe. Length and checksum are validated, and done/error status is reported to the core top, which gates the pipeline and debug display.

---
 rtl/uart_loader_pkg.sv | 6 +
 rtl/uart_rx_byte.sv | 77 +++++++
 rtl/uart_imem_loader.sv | 134 +++++++++++++
 tb/tb_uart_imem_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared FSM state and error-code encodings for the UART imem loader
package uart_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} ldr_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_FRAME, ERR_LEN, ERR_CSUM} err_code_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop synchroniser, start-glitch rejection and framing check
module uart_rx_byte import uart_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t st_q, st_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rxs, half, full;
  assign rxs = sync_q[1];
  assign half = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    sync_d = {sync_q[0], rx};
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) st_d = RX_START;
      end
      RX_START: if (half) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (full) begin
        cnt_d = '0;
        sh_d = {rxs, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      RX_STOP: if (full) begin
        cnt_d = '0;
        st_d = RX_IDLE;
        valid_d = rxs;
        ferr_d = !rxs;
      end
    endcase
  end
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      st_q <= RX_IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign byte_valid = valid_q;
  assign byte_data = sh_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives a length/data/checksum framed UART image and writes it word-by-word into imem
module uart_imem_loader import uart_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int LEN_BYTES = 2
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog,
  input  logic              rx,
  output logic              prog_ena,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_din,
  output logic [ADDR_W:0]   words_written,
  output logic              done,
  output logic [1:0]        err_code
);
  localparam int LW = 8 * LEN_BYTES;
  localparam int BPW = DATA_W / 8;
  localparam int CW = (LW > ADDR_W ? LW : ADDR_W) + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;
  logic byte_valid, frame_err;
  logic [7:0] byte_data;
  ldr_state_t state_q, state_d;
  err_code_t err_q, err_d;
  logic [LW-1:0] len_q, len_d, len_nx;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [DATA_W-1:0] word_q, word_d, word_nx, din_q, din_d;
  logic we_q, we_d, prog_q, prog_d;
  logic [ADDR_W:0] ww_q, ww_d, ww_nx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .Rst(Rst), .rx(rx),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );
  // Little-endian assembly: each new byte enters at the top and earlier bytes slide toward the LSB.
  assign len_nx = (len_q >> 8) | (LW'(byte_data) << (LW - 8));
  assign word_nx = (word_q >> 8) | (DATA_W'(byte_data) << (DATA_W - 8));
  assign ww_nx = ww_q + 1'b1;
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    len_d = len_q;
    idx_d = idx_q;
    sum_d = sum_q;
    word_d = word_q;
    din_d = din_q;
    we_d = 1'b0;
    ww_d = ww_q;
    prog_d = prog;
    addr_d = (we_q && CW'(ww_q) < CW'(len_q)) ? addr_q + 1'b1 : addr_q;
    if (!prog) begin
      state_d = IDLE;
      err_d = ERR_NONE;
    end else if (frame_err && state_q inside {LEN, DATA, CSUM}) begin
      state_d = ERR;
      err_d = ERR_FRAME;
    end else case (state_q)
      IDLE: if (!prog_q) begin
        state_d = LEN;
        err_d = ERR_NONE;
        len_d = '0;
        idx_d = '0;
        sum_d = '0;
        ww_d = '0;
        addr_d = '0;
      end
      LEN: if (byte_valid) begin
        len_d = len_nx;
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(LEN_BYTES - 1)) begin
          idx_d = '0;
          state_d = (CW'(len_nx) > DEPTH) ? ERR : (len_nx == '0) ? CSUM : DATA;
          err_d = (CW'(len_nx) > DEPTH) ? ERR_LEN : ERR_NONE;
        end
      end
      DATA: if (byte_valid) begin
        word_d = word_nx;
        sum_d = sum_q + byte_data;
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(BPW - 1)) begin
          idx_d = '0;
          we_d = 1'b1;
          din_d = word_nx;
          ww_d = ww_nx;
          if (CW'(ww_nx) == CW'(len_q)) state_d = CSUM;
        end
      end
      CSUM: if (byte_valid) begin
        state_d = (byte_data == sum_q) ? DONE : ERR;
        err_d = (byte_data == sum_q) ? ERR_NONE : ERR_CSUM;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      err_q <= ERR_NONE;
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      word_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      ww_q <= '0;
      addr_q <= '0;
      prog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      len_q <= len_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      word_q <= word_d;
      din_q <= din_d;
      we_q <= we_d;
      ww_q <= ww_d;
      addr_q <= addr_d;
      prog_q <= prog_d;
    end
  end
  // A strobe landing in the cycle prog drops must not reach imem.
  assign prog_we = we_q & prog;
  assign prog_ena = state_q != IDLE;
  assign done = state_q == DONE;
  assign err_code = err_q;
  assign prog_addr = addr_q;
  assign prog_din = din_q;
  assign words_written = ww_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed self-checking bench for the UART imem loader
module tb_uart_imem_loader;
  localparam int CPB = 8, DW = 32, AW = 4, LB = 2;
  logic clk = 1'b0, Rst = 1'b1, prog = 1'b0, rx = 1'b1;
  logic prog_ena, prog_we, done;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_din;
  logic [AW:0] words_written;
  logic [1:0] err_code;
  int nt = 0, nf = 0, nw = 0, nbv = 0, base = 0, bvb = 0;
  logic [AW-1:0] wa [0:31];
  logic [DW-1:0] wd [0:31];
  logic [7:0] img [$];
  uart_imem_loader #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ADDR_W(AW), .LEN_BYTES(LB)) dut (
    .clk(clk), .Rst(Rst), .prog(prog), .rx(rx),
    .prog_ena(prog_ena), .prog_we(prog_we), .prog_addr(prog_addr), .prog_din(prog_din),
    .words_written(words_written), .done(done), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (prog_we) begin
      if (nw < 32) begin
        wa[nw] <= prog_addr;
        wd[nw] <= prog_din;
      end
      nw <= nw + 1;
    end
    if (dut.byte_valid) nbv <= nbv + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nt++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic send_q(input logic [7:0] q [$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask
  task automatic end_session(input string tag);
    @(negedge clk);
    prog = 1'b0;
    @(negedge clk);
    chk({tag, "_ena_clr"}, prog_ena, 1'b0);
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_err_clr"}, err_code, 2'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ena", prog_ena, 1'b0);
    chk("rst_we", prog_we, 1'b0);
    chk("rst_addr", prog_addr, '0);
    chk("rst_din", prog_din, '0);
    chk("rst_ww", words_written, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_code, 2'd0);
    Rst = 1'b0;
    // normal two-word load, checksum 13+50+93+10 = 106 -> 06
    @(negedge clk);
    prog = 1'b1;
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h06};
    send_q(img);
    chk("t1_nw", nw, 2);
    chk("t1_a0", wa[0], 4'd0);
    chk("t1_d0", wd[0], 32'h00500013);
    chk("t1_a1", wa[1], 4'd1);
    chk("t1_d1", wd[1], 32'h00100093);
    chk("t1_done", done, 1'b1);
    chk("t1_err", err_code, 2'd0);
    chk("t1_ww", words_written, 5'd2);
    chk("t1_ena", prog_ena, 1'b1);
    end_session("t1");
    // checksum mismatch
    base = nw;
    prog = 1'b1;
    img[10] = 8'h07;
    send_q(img);
    chk("t2_nw", nw - base, 2);
    chk("t2_d1", wd[base + 1], 32'h00100093);
    chk("t2_err", err_code, 2'd3);
    chk("t2_done", done, 1'b0);
    repeat (20) @(negedge clk);
    chk("t2_ena_held", prog_ena, 1'b1);
    end_session("t2");
    // length 17 exceeds depth 16
    base = nw;
    prog = 1'b1;
    img = {8'h11, 8'h00};
    send_q(img);
    chk("t3_err", err_code, 2'd2);
    chk("t3_nw", nw - base, 0);
    chk("t3_ww", words_written, 5'd0);
    end_session("t3");
    // zero-length image goes straight to checksum of 0
    base = nw;
    prog = 1'b1;
    img = {8'h00, 8'h00, 8'h00};
    send_q(img);
    chk("t3b_done", done, 1'b1);
    chk("t3b_nw", nw - base, 0);
    end_session("t3b");
    // framing error on third data byte
    base = nw;
    prog = 1'b1;
    img = {8'h01, 8'h00, 8'h13, 8'h00};
    send_q(img);
    send_byte(8'h50, 1'b0);
    chk("t4_err", err_code, 2'd1);
    chk("t4_nw", nw - base, 0);
    send_byte(8'h00, 1'b1);
    chk("t4_err_hold", err_code, 2'd1);
    chk("t4_nw_hold", nw - base, 0);
    end_session("t4");
    // prog dropped mid-word, then a fresh session restarts at address 0
    base = nw;
    prog = 1'b1;
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    send_q(img);
    @(negedge clk);
    prog = 1'b0;
    @(negedge clk);
    chk("t5_ena", prog_ena, 1'b0);
    chk("t5_nw", nw - base, 1);
    chk("t5_a0", wa[base], 4'd0);
    prog = 1'b1;
    img = {8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hA3};
    send_q(img);
    chk("t5_nw2", nw - base, 2);
    chk("t5_a_new", wa[base + 1], 4'd0);
    chk("t5_d_new", wd[base + 1], 32'h00100093);
    chk("t5_done", done, 1'b1);
    end_session("t5");
    // full-depth image: word i = i, checksum 0+1+..+15 = 0x78
    base = nw;
    prog = 1'b1;
    img = {8'h10, 8'h00};
    for (int i = 0; i < 16; i++) img = {img, 8'(i), 8'h00, 8'h00, 8'h00};
    img = {img, 8'h78};
    send_q(img);
    chk("fd_nw", nw - base, 16);
    chk("fd_ww", words_written, 5'd16);
    chk("fd_a15", wa[base + 15], 4'd15);
    chk("fd_d15", wd[base + 15], 32'd15);
    chk("fd_done", done, 1'b1);
    end_session("fd");
    // async reset in the middle of a data bit
    prog = 1'b1;
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00};
    send_q(img);
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_ena_pre", prog_ena, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk("t6_ena", prog_ena, 1'b0);
    chk("t6_ww", words_written, 5'd0);
    chk("t6_we", prog_we, 1'b0);
    chk("t6_din", prog_din, '0);
    rx = 1'b1;
    prog = 1'b0;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    repeat (4) @(negedge clk);
    // short low glitch while idle
    bvb = nbv;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_glitch_bv", nbv - bvb, 0);
    chk("t6_glitch_ena", prog_ena, 1'b0);
    chk("t6_glitch_err", err_code, 2'd0);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
